// File: rtl/multicore_pkg.sv
// Shared multicore definitions; this slice carries the branch predictor types.
package multicore_pkg;

  localparam int DATA_SIZE    = 32;
  localparam int BP_ENTRIES   = 64;
  // Widest tag any legal table size can need (smallest table has 4 entries).
  localparam int BP_TAG_MAX_W = DATA_SIZE - 4;

  typedef enum logic [1:0] {
    BP_SNT = 2'b00,
    BP_WNT = 2'b01,
    BP_WT  = 2'b10,
    BP_ST  = 2'b11
  } t_bp_cnt;

  typedef struct packed {
    logic                    valid;
    logic [BP_TAG_MAX_W-1:0] tag;
    logic [DATA_SIZE-1:0]    target;
  } t_btb_entry;

  function automatic logic [DATA_SIZE-1:0] bp_seq_pc(input logic [DATA_SIZE-1:0] pc);
    return pc + DATA_SIZE'(32'd4);
  endfunction

endpackage

// File: rtl/sat_counter2.sv
// Two-bit saturating branch counter: next state from (count, taken).
module sat_counter2
  import multicore_pkg::*;
(
  input  t_bp_cnt i_cnt,
  input  logic    i_taken,
  output t_bp_cnt o_cnt
);

  // next-count selection, saturating at both ends
  always_comb begin
    o_cnt = i_cnt;
    case (i_cnt)
      BP_SNT:  o_cnt = i_taken ? BP_WNT : BP_SNT;
      BP_WNT:  o_cnt = i_taken ? BP_WT  : BP_SNT;
      BP_WT:   o_cnt = i_taken ? BP_ST  : BP_WNT;
      BP_ST:   o_cnt = i_taken ? BP_ST  : BP_WT;
      default: o_cnt = BP_WNT;
    endcase
  end

endmodule

// File: rtl/branch_predictor.sv
// Direct-mapped BTB + 2-bit counter predictor with registered mispredict redirect.
// Optional BP_BYPASS_EN: same-index lookup sees the concurrent update (write-through).
module branch_predictor
  import multicore_pkg::*;
#(
  parameter int ENTRIES = BP_ENTRIES
) (
  input  logic                 i_clk,
  input  logic                 i_rst_n,
  input  logic                 i_stall,
  input  logic                 i_flush,
  input  logic                 i_lookup_valid,
  input  logic [DATA_SIZE-1:0] i_lookup_pc,
  output logic                 o_pred_valid,
  output logic                 o_pred_taken,
  output logic [DATA_SIZE-1:0] o_pred_target,
  input  logic                 i_upd_valid,
  input  logic [DATA_SIZE-1:0] i_upd_pc,
  input  logic                 i_upd_taken,
  input  logic [DATA_SIZE-1:0] i_upd_target,
  input  logic                 i_upd_pred_taken,
  input  logic [DATA_SIZE-1:0] i_upd_pred_target,
  output logic                 o_mispredict,
  output logic [DATA_SIZE-1:0] o_redirect_pc
);

  localparam int IDX_W = $clog2(ENTRIES);
  localparam int TAG_W = DATA_SIZE - IDX_W - 2;

  logic [ENTRIES-1:0]   r_valid;
  t_bp_cnt              r_cnt    [ENTRIES];
  logic [TAG_W-1:0]     r_tag    [ENTRIES];
  logic [DATA_SIZE-1:0] r_target [ENTRIES];

  logic                 r_pred_valid;
  logic                 r_pred_taken;
  logic [DATA_SIZE-1:0] r_pred_target;
  logic                 r_mispredict;
  logic [DATA_SIZE-1:0] r_redirect_pc;

  logic [IDX_W-1:0]     w_upd_idx;
  logic [IDX_W-1:0]     w_lk_idx;
  logic [TAG_W-1:0]     w_upd_tag;
  logic [TAG_W-1:0]     w_lk_tag;
  logic                 w_upd_hit;
  logic                 w_cnt_we;
  logic                 w_tgt_we;
  t_bp_cnt              w_upd_cur_cnt;
  t_bp_cnt              w_upd_sat_cnt;
  t_bp_cnt              w_upd_new_cnt;
  logic                 w_lk_fwd;
  t_btb_entry           w_lk_entry;
  t_bp_cnt              w_lk_cnt;
  logic                 w_lk_hit;
  logic                 w_lk_taken;
  logic [DATA_SIZE-1:0] w_lk_target;
  logic [DATA_SIZE-1:0] w_upd_correct;
  logic                 w_upd_wrong;

  assign w_upd_idx = i_upd_pc[IDX_W+1:2];
  assign w_upd_tag = i_upd_pc[DATA_SIZE-1:IDX_W+2];
  assign w_lk_idx  = i_lookup_pc[IDX_W+1:2];
  assign w_lk_tag  = i_lookup_pc[DATA_SIZE-1:IDX_W+2];

  // A hit trains the counter; any taken outcome (hit or allocate) writes tag/target.
  assign w_upd_hit     = r_valid[w_upd_idx] & (r_tag[w_upd_idx] == w_upd_tag);
  assign w_cnt_we      = i_upd_valid & (w_upd_hit | i_upd_taken);
  assign w_tgt_we      = i_upd_valid & i_upd_taken;
  assign w_upd_cur_cnt = r_cnt[w_upd_idx];
  assign w_upd_new_cnt = w_upd_hit ? w_upd_sat_cnt : BP_WT;

  sat_counter2 u_sat_counter2 (
    .i_cnt   (w_upd_cur_cnt),
    .i_taken (i_upd_taken),
    .o_cnt   (w_upd_sat_cnt)
  );

`ifdef BP_BYPASS_EN
  assign w_lk_fwd = i_upd_valid & (w_upd_idx == w_lk_idx);
`else
  assign w_lk_fwd = 1'b0;
`endif

  // lookup read view, optionally forwarded from the concurrent update
  always_comb begin
    w_lk_entry.valid  = r_valid[w_lk_idx] | (w_lk_fwd & w_tgt_we);
    w_lk_entry.tag    = (w_lk_fwd & w_tgt_we) ? BP_TAG_MAX_W'(w_upd_tag)
                                              : BP_TAG_MAX_W'(r_tag[w_lk_idx]);
    w_lk_entry.target = (w_lk_fwd & w_tgt_we) ? i_upd_target : r_target[w_lk_idx];
    w_lk_cnt          = (w_lk_fwd & w_cnt_we) ? w_upd_new_cnt : r_cnt[w_lk_idx];
    w_lk_hit          = w_lk_entry.valid & (w_lk_entry.tag == BP_TAG_MAX_W'(w_lk_tag));
    w_lk_taken        = w_lk_hit & w_lk_cnt[1];
    w_lk_target       = w_lk_taken ? w_lk_entry.target : bp_seq_pc(i_lookup_pc);
  end

  assign w_upd_correct = i_upd_taken ? i_upd_target : bp_seq_pc(i_upd_pc);
  assign w_upd_wrong   = (i_upd_pred_taken != i_upd_taken) |
                         (w_upd_correct != i_upd_pred_target);

  // valid bits and counters: reset discards all history
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_valid <= {ENTRIES{1'b0}};
      for (int i = 0; i < ENTRIES; i++) begin
        r_cnt[i] <= BP_WNT;
      end
    end else begin
      if (w_tgt_we) begin
        r_valid[w_upd_idx] <= 1'b1;
      end
      if (w_cnt_we) begin
        r_cnt[w_upd_idx] <= w_upd_new_cnt;
      end
    end
  end

  // tag/target storage, qualified by the valid bits so no reset needed
  always_ff @(posedge i_clk) begin
    if (w_tgt_we) begin
      r_tag[w_upd_idx]    <= w_upd_tag;
      r_target[w_upd_idx] <= i_upd_target;
    end
  end

  // prediction output register: flush beats stall beats lookup
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_pred_valid  <= 1'b0;
      r_pred_taken  <= 1'b0;
      r_pred_target <= {DATA_SIZE{1'b0}};
    end else if (i_flush) begin
      r_pred_valid  <= 1'b0;
    end else if (i_stall) begin
      r_pred_valid  <= r_pred_valid;
    end else if (i_lookup_valid) begin
      r_pred_valid  <= 1'b1;
      r_pred_taken  <= w_lk_taken;
      r_pred_target <= w_lk_target;
    end else begin
      r_pred_valid  <= 1'b0;
    end
  end

  // mispredict pulse and redirect target
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_mispredict  <= 1'b0;
      r_redirect_pc <= {DATA_SIZE{1'b0}};
    end else if (i_upd_valid) begin
      r_mispredict  <= w_upd_wrong;
      r_redirect_pc <= w_upd_correct;
    end else begin
      r_mispredict  <= 1'b0;
    end
  end

  assign o_pred_valid  = r_pred_valid;
  assign o_pred_taken  = r_pred_taken;
  assign o_pred_target = r_pred_target;
  assign o_mispredict  = r_mispredict;
  assign o_redirect_pc = r_redirect_pc;

endmodule
